// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register: one WIDTH-bit payload word per transfer, with valid/ready
// handshake, optional two-entry skid buffer, and global stall/flush.
// Latency: one cycle from in_fire to out_valid_o. Throughput: one word per cycle.
// Backpressure: with SKID=1, in_ready_o comes from a flop and falls once both entries
// are full. With SKID=0, in_ready_o is combinational from out_ready_i.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   flush_i         - discard all held entries (beats stall and handshake)
//   stall_i         - freeze all state; no transfer in or out
//   in_valid_i/in_ready_o/in_data_i    - upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o - downstream handshake and payload
//   occupancy_o     - number of held entries (0..2 with skid, 0..1 without)
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      SKID      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             stall_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [1:0]       occupancy_o
);

   // Main entry M: always drives the output port.
   logic             m_vld_q, m_vld_d;
   logic [WIDTH-1:0] m_dat_q, m_dat_d;

   logic in_fire;
   logic out_fire;

   // Stall gates both fire terms. Upstream sees the same stall, so in_ready_o
   // itself does not need to depend on it in skid mode.
   assign in_fire  = in_valid_i & in_ready_o & ~stall_i;
   assign out_fire = m_vld_q & out_ready_i & ~stall_i;

   assign out_valid_o = m_vld_q;
   assign out_data_o  = m_dat_q;

   // Reset and flush have the same effect. Any same-cycle in_fire is dropped,
   // because the _d values are ignored here.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         m_vld_q <= 1'b0;
         m_dat_q <= RESET_VAL;
      end else begin
         m_vld_q <= m_vld_d;
         m_dat_q <= m_dat_d;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         // Skid entry S: catches the word that arrives while M is full and not draining.
         logic             s_vld_q, s_vld_d;
         logic [WIDTH-1:0] s_dat_q, s_dat_d;

         // S empty means one free slot is guaranteed next cycle. This keeps the
         // ready path registered.
         assign in_ready_o  = ~s_vld_q;
         assign occupancy_o = {1'b0, m_vld_q} + {1'b0, s_vld_q};

         always_comb begin
            m_vld_d = m_vld_q;
            m_dat_d = m_dat_q;
            s_vld_d = s_vld_q;
            s_dat_d = s_dat_q;
            if (out_fire && s_vld_q) begin
               // S refills M. No in_fire can coincide, because in_ready_o is low.
               m_dat_d = s_dat_q;
               s_vld_d = 1'b0;
            end else if (in_fire) begin
               if (!m_vld_q || out_fire) begin
                  m_dat_d = in_data_i;
                  m_vld_d = 1'b1;
               end else begin
                  s_dat_d = in_data_i;
                  s_vld_d = 1'b1;
               end
            end else if (out_fire) begin
               m_vld_d = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst || flush_i) begin
               s_vld_q <= 1'b0;
               s_dat_q <= '0;
            end else begin
               s_vld_q <= s_vld_d;
               s_dat_q <= s_dat_d;
            end
         end
      end else begin : g_noskid
         // Single entry: the stage can accept if it is empty, or if M leaves this cycle.
         assign in_ready_o  = ~m_vld_q | (out_ready_i & ~stall_i);
         assign occupancy_o = {1'b0, m_vld_q};

         always_comb begin
            m_vld_d = m_vld_q;
            m_dat_d = m_dat_q;
            if (in_fire) begin
               m_dat_d = in_data_i;
               m_vld_d = 1'b1;
            end else if (out_fire) begin
               m_vld_d = 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Two instances are driven side by side:
// instance 0 has SKID=1 and instance 1 has SKID=0.
// Both are compared every cycle against a queue model of the stage.
module tb_pipe_stage_reg;
   typedef logic [15:0] word_t;
   localparam word_t RV = 16'hDEAD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, flush, stall, ordy;
   logic       iv[2];
   word_t      id[2];
   logic       ir[2];
   logic       ov[2];
   word_t      od[2];
   logic [1:0] occ[2];

   pipe_stage_reg #(.WIDTH(16), .RESET_VAL(RV), .SKID(1)) u_skid (
      .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
      .in_valid_i(iv[0]), .in_ready_o(ir[0]), .in_data_i(id[0]),
      .out_valid_o(ov[0]), .out_ready_i(ordy), .out_data_o(od[0]),
      .occupancy_o(occ[0]));

   pipe_stage_reg #(.WIDTH(16), .RESET_VAL(RV), .SKID(0)) u_noskid (
      .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall),
      .in_valid_i(iv[1]), .in_ready_o(ir[1]), .in_data_i(id[1]),
      .out_valid_o(ov[1]), .out_ready_i(ordy), .out_data_o(od[1]),
      .occupancy_o(occ[1]));

   int    n_vec = 0;
   int    n_err = 0;
   word_t mq[2][$];   // words held by each stage, oldest first
   word_t hold[2];    // value shown on out_data_o while the stage is empty
   logic  acc[2];     // the offer in the last step was accepted

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
      end
   endtask

   // One clock cycle. Inputs are applied at the negedge and outputs are checked 1 time
   // unit later. The model advances at the posedge. The task returns at the next negedge.
   task automatic step(input logic r, input logic f, input logic s, input logic o,
                       input logic v0, input word_t d0, input logic v1, input word_t d1);
      logic e_rdy[2];
      rst = r; flush = f; stall = s; ordy = o;
      iv[0] = v0; id[0] = d0; iv[1] = v1; id[1] = d1;
      #1;
      for (int k = 0; k < 2; k++) begin
         int sz = mq[k].size();
         if (k == 0) e_rdy[k] = (sz < 2);
         else        e_rdy[k] = (sz == 0) || (o && !s);
         check_val($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(e_rdy[k]));
         check_val($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(sz > 0));
         check_val($sformatf("out_data[%0d]", k), 32'(od[k]),
                   32'((sz > 0) ? mq[k][0] : hold[k]));
         check_val($sformatf("occupancy[%0d]", k), 32'(occ[k]), 32'(sz));
         acc[k] = iv[k] && e_rdy[k] && !s && !r && !f;
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r || f) begin
            mq[k].delete();
            hold[k] = RV;
         end else if (!s) begin
            if (mq[k].size() > 0 && o) hold[k] = mq[k].pop_front();
            if (acc[k]) mq[k].push_back((k == 0) ? d0 : d1);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic  r, f, s, o, v0, v1;
      word_t d0, d1, c0, c1;

      rst = 1'b1; flush = 1'b0; stall = 1'b0; ordy = 1'b0;
      iv[0] = 1'b1; iv[1] = 1'b1; id[0] = 16'h00AA; id[1] = 16'h00AA;
      hold[0] = RV; hold[1] = RV;
      acc[0] = 1'b1; acc[1] = 1'b1;
      // The first reset edge takes the registers out of X. Checking starts after it.
      @(negedge clk);
      step(1, 0, 0, 0, 1, 16'h00AA, 1, 16'h00AA);
      check_val("rst_out_data", 32'(od[0]), 32'(RV));
      check_val("rst_out_valid", 32'(ov[0]), 32'd0);
      check_val("rst_in_ready", 32'(ir[0]), 32'd1);
      check_val("rst_occupancy", 32'(occ[0]), 32'd0);

      // Streaming: words 1..8 on consecutive cycles
      for (int i = 1; i <= 8; i++) step(0, 0, 0, 1, 1, word_t'(i), 1, word_t'(i));
      step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);
      step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);

      // Back-pressure and skid
      step(0, 0, 0, 0, 1, 16'h0011, 1, 16'h0011);
      step(0, 0, 0, 0, 1, 16'h0022, 1, 16'h0022);
      check_val("skid_occupancy", 32'(occ[0]), 32'd2);
      check_val("skid_in_ready", 32'(ir[0]), 32'd0);
      step(0, 0, 0, 0, 1, 16'h0033, 1, 16'h0033);
      step(0, 0, 0, 1, 1, 16'h0033, 1, 16'h0033);
      check_val("skid_move_data", 32'(od[0]), 32'h0022);
      check_val("skid_ready_back", 32'(ir[0]), 32'd1);
      step(0, 0, 0, 1, 1, 16'h0033, 1, 16'h0033);
      check_val("skid_third_word", 32'(od[0]), 32'h0033);
      step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);
      step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);

      // Stall holds the stage while both sides are willing
      step(0, 0, 0, 0, 1, 16'h0044, 1, 16'h0044);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 1, 16'h0055, 1, 16'h0055);
         check_val("stall_out_data", 32'(od[0]), 32'h0044);
         check_val("stall_occupancy", 32'(occ[0]), 32'd1);
      end
      step(0, 0, 0, 1, 1, 16'h0055, 1, 16'h0055);
      check_val("stall_release", 32'(od[0]), 32'h0055);
      step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);

      // Flush beats stall and discards both held words and the offered word
      step(0, 0, 0, 0, 1, 16'h0066, 1, 16'h0066);
      step(0, 0, 0, 0, 1, 16'h0077, 1, 16'h0077);
      step(0, 1, 1, 0, 1, 16'h0088, 1, 16'h0088);
      check_val("flush_occupancy", 32'(occ[0]), 32'd0);
      check_val("flush_out_valid", 32'(ov[0]), 32'd0);
      check_val("flush_out_data", 32'(od[0]), 32'(RV));
      step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);
      step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);

      // Toggle out_ready 1,0,1,0 with continuous input. Each upstream advances only on accept.
      c0 = 16'h0100; c1 = 16'h0200;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, (i % 2 == 0), 1, c0, 1, c1);
         if (acc[0]) c0 = c0 + 16'h1;
         if (acc[1]) c1 = c1 + 16'h1;
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 16'h0, 0, 16'h0);

      // Randomized traffic. Each upstream holds its offer until it is accepted.
      v0 = 1'b0; v1 = 1'b0; d0 = 16'h0; d1 = 16'h0;
      acc[0] = 1'b1; acc[1] = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         f = ($urandom_range(0, 49) == 0);
         s = ($urandom_range(0, 7) == 0);
         o = ($urandom_range(0, 9) < 6);
         if (!v0 || acc[0]) begin
            v0 = ($urandom_range(0, 9) < 7);
            d0 = word_t'($urandom);
         end
         if (!v1 || acc[1]) begin
            v1 = ($urandom_range(0, 9) < 7);
            d1 = word_t'($urandom);
         end
         step(r, f, s, o, v0, d0, v1, d1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline-stage register with a valid/ready handshake, optional two-entry skid buffer, and global stall/flush control. It replaces hand-written per-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). Each stage packs its control and data fields into one `WIDTH`-bit bus. It adds back-pressure, which a plain stall-hold register lacks, and keeps one-transfer-per-cycle throughput.

## Interface
Parameters:
- `WIDTH`, default 64: payload bus width; legal range ≥ 1.
- `RESET_VAL`, default `'0`: `WIDTH`-bit value `out_data_o` takes on reset and flush.
- `SKID`, default 1:
  - 1: two-entry skid buffer; `in_ready_o` is driven from a flop.
  - 0: single entry; `in_ready_o` is combinational from `out_ready_i`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `flush_i`, input, 1: synchronous discard of all held entries.
- `stall_i`, input, 1: freezes this stage; no transfer in or out.
- `in_valid_i`, input, 1: upstream offers `in_data_i`.
- `in_ready_o`, output, 1: the stage can accept a word.
- `in_data_i`, input, `WIDTH`: upstream payload.
- `out_valid_o`, output, 1: `out_data_o` is valid.
- `out_ready_i`, input, 1: downstream accepts.
- `out_data_o`, output, `WIDTH`: payload to the next stage.
- `occupancy_o`, output, 2: number of held entries (0–2 when `SKID`=1, 0–1 when `SKID`=0).

## Operation
Transfer conditions:
- `in_fire` = `in_valid_i & in_ready_o & ~stall_i`.
- `out_fire` = `out_valid_o & out_ready_i & ~stall_i`.
- `in_ready_o` does not depend on `stall_i`. Upstream stages receive the same stall, so gating both fire terms is sufficient.

Priority, highest first: `rst`, `flush_i`, `stall_i`, normal handshake.

Reset and flush (same cycle effect):
- `out_valid_o`=0, skid entry invalid, `occupancy_o`=0.
- `out_data_o`=`RESET_VAL`, `in_ready_o`=1 on the next cycle.
- Any simultaneous `in_fire` is dropped and does not appear later.

Stall:
- All state is held: main entry, skid entry, valid bits, `out_data_o`.
- The handshake is ignored.

`SKID`=1 (main entry M, skid entry S):
- `in_ready_o` = ~S.valid, taken from a flop.
- `in_fire` with M empty, or with `out_fire` the same cycle: data loads into M and M.valid=1.
- `in_fire` with M full and no `out_fire`: data loads into S.
- `out_fire` with S valid: S moves to M and S clears. `in_fire` cannot coincide, because `in_ready_o`=0.
- `out_fire` with S empty and no `in_fire`: M.valid=0.

`SKID`=0:
- `in_ready_o` = ~`out_valid_o` | (`out_ready_i` & ~`stall_i`).
- `in_fire` loads M.
- `out_fire` without `in_fire` clears M.valid.

Outputs:
- `out_data_o` always shows M's data. It holds its last value when `out_valid_o`=0, except after reset/flush, when it is `RESET_VAL`.
- `occupancy_o` = M.valid + S.valid.
- Order is strictly FIFO; no word is duplicated or lost except by flush.

## Timing
- Latency: an `in_fire` in cycle n into an empty stage gives `out_valid_o`=1 with that data in cycle n+1.
- Throughput: 1 word/cycle sustained while `out_ready_i`=1 in both modes.
- `SKID`=1: `in_ready_o` falls in the cycle after the second word is accepted without drain. It rises in the cycle after the `out_fire` that empties S.
- `SKID`=0: there is a combinational path `out_ready_i` → `in_ready_o`.
- Reset values, visible on the cycle after `rst`=1: `out_valid_o`=0, `in_ready_o`=1, `out_data_o`=`RESET_VAL`, `occupancy_o`=0.
- A flush asserted mid-stream takes effect at that edge. `out_valid_o` is 0 in the next cycle regardless of `out_ready_i`.

## Test plan
- Reset: `rst`=1 for 2 cycles with `in_valid_i`=1 and `in_data_i`=0xAA → `out_valid_o`=0, `out_data_o`=`RESET_VAL`, `in_ready_o`=1, `occupancy_o`=0.
- Streaming (`SKID`=1): `out_ready_i`=1, words 1..8 sent on consecutive cycles → words 1..8 appear on consecutive cycles, one-cycle latency, `in_ready_o` stays 1.
- Back-pressure and skid: `out_ready_i`=0, send 0x11 then 0x22 →
  - `occupancy_o`=2 and `in_ready_o`=0 on the third cycle;
  - 0x33 is held off upstream;
  - on raising `out_ready_i`, the output order is 0x11, 0x22, 0x33;
  - `in_ready_o` returns to 1 one cycle after 0x22 moves to M.
- Stall: while `occupancy_o`=1 and `out_data_o`=0x44, assert `stall_i` for 3 cycles with `out_ready_i`=1 and `in_valid_i`=1 → `out_data_o` stays 0x44, `occupancy_o` stays 1, no word is consumed; after release, 0x44 then the pending input are delivered.
- Flush priority: `occupancy_o`=2, assert `flush_i` and `stall_i` together with `in_valid_i`=1 → next cycle `occupancy_o`=0, `out_valid_o`=0, `out_data_o`=`RESET_VAL`; neither the held words nor the offered word ever appear.
- `SKID`=0 instance: `out_ready_i` toggling 1,0,1,0 with continuous input → `in_ready_o` follows `out_ready_i` in the same cycle whenever `out_valid_o`=1; all words are delivered in order with no loss.
